audio_sample_streamer: RTL

- Sits directly downstream of the flash driver.
- Accepts the 8-bit audio samples it produces and buffers them in a small FIFO.
- Scales each sample to 16-bit signed and delivers it to the board audio codec core over its ready/write handshake, same value on left and right.
- Decouples the divided fetch rate from codec back-pressure and reports overflow.

---
 rtl/audio_sample_streamer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/audio_sample_streamer.sv
// Buffers 8-bit flash audio samples in a FIFO and streams them, scaled to 16-bit, to the codec.
// Optional build macro UNDERRUN_REPEAT_EN: re-send the last sample when the FIFO starves.
module audio_sample_streamer #(
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         sample_in,
    input  logic               sample_valid,
    input  logic               mute,
    input  logic [2:0]         atten,
    input  logic               clear_overflow,
    input  logic               audio_write_ready,
    output logic               audio_write,
    output logic [15:0]        audio_left,
    output logic [15:0]        audio_right,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [7:0]         mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LEVEL_W-1:0] level_r;
    logic               empty_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
`ifdef UNDERRUN_REPEAT_EN
    logic               underrun_arm_r;
`endif

    function automatic logic [15:0] scale_sample(input logic [7:0] sample,
                                                 input logic [2:0] shift,
                                                 input logic       silence);
        logic signed [15:0] wide;
        wide = $signed({sample, 8'h00});
        if (silence) begin
            return 16'h0000;
        end else begin
            return 16'(wide >>> shift);
        end
    endfunction

    assign empty_s    = (level_r == LEVEL_W'(0));
    assign full_s     = (level_r == LEVEL_W'(DEPTH));
    assign fifo_level = level_r;

    // Next-state and pop decision; pop only sees occupancy from the start of the cycle.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && audio_write_ready) begin
                    pop_s        = 1'b1;
                    state_next_s = WRITE;
`ifdef UNDERRUN_REPEAT_EN
                end else if (empty_s && audio_write_ready && underrun_arm_r) begin
                    state_next_s = WRITE;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        push_s = sample_valid && (!full_s || pop_s);
        drop_s = sample_valid && full_s && !pop_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LEVEL_W'(0);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sample_in;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_W'(1);
                2'b01:   level_r <= level_r - LEVEL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Codec outputs; left/right hold between pops, mute/atten applied at pop time.
    always_ff @(posedge clk) begin
        if (reset) begin
            audio_write <= 1'b0;
            audio_left  <= 16'h0000;
            audio_right <= 16'h0000;
        end else begin
            audio_write <= (state_next_s == WRITE);
            if (pop_s) begin
                audio_left  <= scale_sample(mem_r[rd_ptr_r], atten, mute);
                audio_right <= scale_sample(mem_r[rd_ptr_r], atten, mute);
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end

`ifdef UNDERRUN_REPEAT_EN
    // Arms after one idle starved cycle so the second consecutive one triggers a repeat.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_arm_r <= 1'b0;
        end else begin
            underrun_arm_r <= (state_r == IDLE) && empty_s && audio_write_ready && !underrun_arm_r;
        end
    end
`endif

endmodule
